// File: rtl/lane_arb_pkg.sv
// lane_arb_pkg: shared FSM state encoding and default sizes for the 2:1 lane arbiter
// IDLE/GNT0/GNT1 encodings double as the one-hot grant vector and are reused by bench monitors.
package lane_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: clearable burst counter flagging the final pop of a burst
// ports: clk, rst (async, active-high), clr, en in; last out (count == BURST_MAX-1)
module arb_burst_counter import lane_arb_pkg::*; #(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = BURST_MAX > 1 ? $clog2(BURST_MAX) : 1;
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(BURST_MAX - 1);
  // wraps on its own so an unlimited burst never runs past the last code
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || (en && last)) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
endmodule

// File: rtl/lane_arbiter_2x1.sv
// lane_arbiter_2x1: round-robin 2:1 lane scheduler with burst limit and downstream back-pressure
// ports: clk_4f, reset (async, active-high); fifo_empty_0/1, fifo_data_0/1, down_almost_full in;
//        pop_0/1 out (combinational); data_out, valid_out (registered); grant (one-hot owner), idle
// LANE_ARB_STRICT_PRIO_EN: lane 0 wins every pick and is never burst-limited
module lane_arbiter_2x1 import lane_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic [DATA_W-1:0] fifo_data_0,
  input  logic [DATA_W-1:0] fifo_data_1,
  output logic              pop_0,
  output logic              pop_1,
  input  logic              down_almost_full,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant,
  output logic              idle
);
  state_t state, nxt, pick, other;
  logic last, cnt_last, cnt_clr, cnt_en, other_ne, no_limit;
  assign pop_0 = state == GNT0 && !fifo_empty_0 && !down_almost_full;
  assign pop_1 = state == GNT1 && !fifo_empty_1 && !down_almost_full;
  assign grant = state;
  assign idle = state == IDLE;
`ifdef LANE_ARB_STRICT_PRIO_EN
  assign pick = !fifo_empty_0 ? GNT0 : !fifo_empty_1 ? GNT1 : IDLE;
  assign no_limit = state == GNT0;
`else
  // both busy: the lane other than last; otherwise whichever has data
  assign pick = !fifo_empty_0 && (fifo_empty_1 || last) ? GNT0 : !fifo_empty_1 ? GNT1 : IDLE;
  assign no_limit = 1'b0;
`endif
  assign other = state == GNT0 ? GNT1 : GNT0;
  assign other_ne = state == GNT0 ? !fifo_empty_1 : !fifo_empty_0;
  // in a grant state with no back-pressure, no pop means the owner ran dry
  always_comb begin
    nxt = state;
    cnt_clr = 1'b0;
    cnt_en = 1'b0;
    if (state == IDLE || (!down_almost_full && !pop_0 && !pop_1)) begin
      nxt = pick;
      cnt_clr = 1'b1;
    end else if (!down_almost_full && cnt_last && !no_limit) begin
      nxt = other_ne ? other : state;
      cnt_clr = 1'b1;
    end else if (!down_almost_full) cnt_en = 1'b1;
  end
  always_ff @(posedge clk_4f or posedge reset)
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      data_out <= '0;
      valid_out <= 1'b0;
    end else begin
      state <= nxt;
      last <= nxt == GNT0 ? 1'b0 : nxt == GNT1 ? 1'b1 : last;
      valid_out <= pop_0 || pop_1;
      if (pop_0 || pop_1) data_out <= pop_0 ? fifo_data_0 : fifo_data_1;
    end
  arb_burst_counter #(.BURST_MAX(BURST_MAX)) u_cnt (
    .clk (clk_4f),
    .rst (reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .last(cnt_last)
  );
endmodule

// File: tb/tb_lane_arbiter_2x1.sv
// tb_lane_arbiter_2x1: scoreboard bench for lane_arbiter_2x1 with two modelled lane FIFOs
module tb_lane_arbiter_2x1;
  import lane_arb_pkg::*;
  logic clk_4f = 1'b0;
  logic reset = 1'b1;
  logic down_almost_full = 1'b0;
  logic fifo_empty_0, fifo_empty_1, pop_0, pop_1, valid_out, idle;
  logic [7:0] fifo_data_0, fifo_data_1, data_out;
  logic [1:0] grant;
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic [7:0] exp_q [$];
  int vectors = 0, errors = 0;

  always #5 clk_4f = ~clk_4f;

  assign fifo_empty_0 = rd0 == wr0;
  assign fifo_empty_1 = rd1 == wr1;
  assign fifo_data_0 = mem0[rd0[5:0]];
  assign fifo_data_1 = mem1[rd1[5:0]];
  always @(posedge clk_4f) begin
    if (pop_0 && rd0 != wr0) rd0 <= rd0 + 1;
    if (pop_1 && rd1 != wr1) rd1 <= rd1 + 1;
  end

  lane_arbiter_2x1 dut (
    .clk_4f          (clk_4f),
    .reset           (reset),
    .fifo_empty_0    (fifo_empty_0),
    .fifo_empty_1    (fifo_empty_1),
    .fifo_data_0     (fifo_data_0),
    .fifo_data_1     (fifo_data_1),
    .pop_0           (pop_0),
    .pop_1           (pop_1),
    .down_almost_full(down_almost_full),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .grant           (grant),
    .idle            (idle)
  );

  task automatic push0(input logic [7:0] d);
    mem0[wr0[5:0]] = d;
    wr0++;
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wr1[5:0]] = d;
    wr1++;
  endtask

  task automatic test_reset;
    push0(8'h10); push0(8'h11); push1(8'h20); push1(8'h21);
    repeat (3) @(negedge clk_4f);
    vectors++; if (data_out !== 8'h00) begin $display("FAIL reset_data_out got %h want 00", data_out); errors++; end
    vectors++; if (valid_out !== 1'b0) begin $display("FAIL reset_valid got %b want 0", valid_out); errors++; end
    vectors++; if (pop_0 !== 1'b0) begin $display("FAIL reset_pop_0 got %b want 0", pop_0); errors++; end
    vectors++; if (pop_1 !== 1'b0) begin $display("FAIL reset_pop_1 got %b want 0", pop_1); errors++; end
    vectors++; if (grant !== IDLE) begin $display("FAIL reset_grant got %b want 00", grant); errors++; end
    vectors++; if (idle !== 1'b1) begin $display("FAIL reset_idle got %b want 1", idle); errors++; end
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    reset = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk_4f);
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL first_order got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin vectors++; errors++; $display("FAIL first_timeout missing %0d want 0", exp_q.size()); exp_q.delete(); end
    repeat (2) @(negedge clk_4f);
    vectors++; if (idle !== 1'b1 || valid_out !== 1'b0) begin $display("FAIL first_idle got idle=%b valid=%b want 1 0", idle, valid_out); errors++; end
  endtask

  task automatic test_round_robin;
    int gaps = 0;
    bit started = 0;
    for (int i = 0; i < 8; i++) begin
      push0(8'(8'hA1 + i));
      push1(8'(8'hB1 + i));
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA1 + 4 * k + i));
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hB1 + 4 * k + i));
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk_4f);
      if (pop_0 && pop_1) begin vectors++; errors++; $display("FAIL rr_one_pop got 11 want one-hot"); end
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL rr_order got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
        started = 1;
      end else if (started) gaps++;
    end
    if (exp_q.size() != 0) begin vectors++; errors++; $display("FAIL rr_timeout missing %0d want 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (gaps != 0) begin $display("FAIL rr_gaps got %0d want 0", gaps); errors++; end
    repeat (2) @(negedge clk_4f);
    vectors++; if (idle !== 1'b1) begin $display("FAIL rr_idle got %b want 1", idle); errors++; end
  endtask

  task automatic test_backpressure;
    int n_rx = 0, gap = 0, bad = 0, daf_n = 0;
    for (int i = 0; i < 6; i++) push0(8'(8'hC1 + i));
    push1(8'hD1); push1(8'hD2);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hC1 + i));
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2);
    exp_q.push_back(8'hC5); exp_q.push_back(8'hC6);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk_4f);
      if (down_almost_full && (pop_0 || pop_1)) bad++;
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL bp_order got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
        n_rx++;
      end else if (n_rx == 2) gap++;
      if (n_rx == 2 && daf_n < 2) begin
        down_almost_full = 1'b1;
        daf_n++;
      end else down_almost_full = 1'b0;
    end
    down_almost_full = 1'b0;
    if (exp_q.size() != 0) begin vectors++; errors++; $display("FAIL bp_timeout missing %0d want 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (gap != 2) begin $display("FAIL bp_gap got %0d want 2", gap); errors++; end
    vectors++; if (bad != 0) begin $display("FAIL bp_pop_under_pressure got %0d want 0", bad); errors++; end
    repeat (2) @(negedge clk_4f);
    vectors++; if (idle !== 1'b1) begin $display("FAIL bp_idle got %b want 1", idle); errors++; end
  endtask

  task automatic test_lane0_only;
    logic [4:0] p0, vld;
    p0 = 5'b00111;
    vld = 5'b01110;
    for (int i = 0; i < 3; i++) begin
      push0(8'(8'hA1 + i));
      exp_q.push_back(8'(8'hA1 + i));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_4f);
      vectors++; if (pop_0 !== p0[c] || pop_1 !== 1'b0) begin $display("FAIL l0_pops cycle %0d got %b%b want 0%b", c, pop_1, pop_0, p0[c]); errors++; end
      vectors++; if (grant !== (c < 4 ? 2'b01 : 2'b00)) begin $display("FAIL l0_grant cycle %0d got %b want %b", c, grant, (c < 4 ? 2'b01 : 2'b00)); errors++; end
      vectors++; if (valid_out !== vld[c]) begin $display("FAIL l0_valid cycle %0d got %b want %b", c, valid_out, vld[c]); errors++; end
      if (valid_out && exp_q.size() > 0) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL l0_data got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
      end
    end
    vectors++; if (idle !== 1'b1 || exp_q.size() != 0) begin $display("FAIL l0_end got idle=%b left=%0d want 1 0", idle, exp_q.size()); errors++; end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int n_rx = 0;
    for (int i = 0; i < 6; i++) push1(8'(8'hF1 + i));
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    for (int c = 0; c < 20 && n_rx < 2; c++) begin
      @(negedge clk_4f);
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL mid_pre got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
        n_rx++;
      end
    end
    vectors++; if (n_rx != 2 || grant !== GNT1) begin $display("FAIL mid_setup got n=%0d grant=%b want 2 10", n_rx, grant); errors++; end
    for (int i = 0; i < 3; i++) push0(8'(8'hE1 + i));
    #2 reset = 1'b1;
    #1;
    vectors++; if (valid_out !== 1'b0 || data_out !== 8'h00) begin $display("FAIL mid_clear got valid=%b data=%h want 0 00", valid_out, data_out); errors++; end
    vectors++; if (grant !== IDLE || idle !== 1'b1) begin $display("FAIL mid_state got grant=%b idle=%b want 00 1", grant, idle); errors++; end
    vectors++; if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin $display("FAIL mid_pops got %b%b want 00", pop_1, pop_0); errors++; end
    @(negedge clk_4f);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'hE1 + i));
    for (int i = 2; i < 6; i++) exp_q.push_back(8'(8'hF1 + i));
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk_4f);
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL mid_post got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin vectors++; errors++; $display("FAIL mid_timeout missing %0d want 0", exp_q.size()); exp_q.delete(); end
    repeat (2) @(negedge clk_4f);
    vectors++; if (idle !== 1'b1) begin $display("FAIL mid_idle got %b want 1", idle); errors++; end
  endtask

`ifdef LANE_ARB_STRICT_PRIO_EN
  task automatic test_strict_prio;
    int n_rx = 0, bad = 0;
    for (int i = 0; i < 6; i++) begin
      push0(8'(8'h31 + i));
      push1(8'(8'h41 + i));
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h31 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h41 + i));
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h45); exp_q.push_back(8'h46);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(negedge clk_4f);
      if (pop_1 && n_rx < 6) bad++;
      if (valid_out) begin
        vectors++;
        if (data_out !== exp_q[0]) begin $display("FAIL sp_order got %h want %h", data_out, exp_q[0]); errors++; end
        void'(exp_q.pop_front());
        n_rx++;
        if (n_rx == 8) begin push0(8'h51); push0(8'h52); end
      end
    end
    if (exp_q.size() != 0) begin vectors++; errors++; $display("FAIL sp_timeout missing %0d want 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (bad != 0) begin $display("FAIL sp_early_pop_1 got %0d want 0", bad); errors++; end
    repeat (2) @(negedge clk_4f);
    vectors++; if (idle !== 1'b1) begin $display("FAIL sp_idle got %b want 1", idle); errors++; end
  endtask
`endif

  initial begin
    test_reset;
    test_round_robin;
    test_backpressure;
    test_lane0_only;
    test_reset_mid;
`ifdef LANE_ARB_STRICT_PRIO_EN
    test_strict_prio;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
